// File: rtl/sample_count_pkg.sv
// Shared types and default parameters for the multi-channel sample block counter.
package sample_count_pkg;

    localparam int DEF_WIDTH  = 10;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_LEN    = 1000;

    typedef enum logic {
        COUNT = 1'b0,
        HOLD  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/block_count_chan.sv
// One counter channel: counts strobes up to a programmable block length and
// raises completion, sticky done and sticky overrun flags.
module block_count_chan
    import sample_count_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_LEN = DEF_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_up,
    input  logic             clear,
    input  logic             ack,
    input  logic             oneshot,
    input  logic             len_we,
    input  logic [WIDTH-1:0] len_wdata,
    output logic [WIDTH-1:0] count,
    output logic             done_pulse,
    output logic             block_done,
    output logic             overrun,
    output logic             active
);

    chan_state_t      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             done_pulse_q, done_pulse_d;
    logic             block_done_q, block_done_d;
    logic             overrun_q, overrun_d;
    logic             active_q, active_d;
    logic             complete_s;

    // >= rather than == so a length shrunk below the current count completes on the next strobe
    assign complete_s = (state_q == COUNT) && cnt_up && (count_q >= (len_q - WIDTH'(1)));

    // Next-state decode: clear beats everything, then HOLD handling, then counting
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        done_pulse_d = 1'b0;
        block_done_d = block_done_q;
        overrun_d    = overrun_q;
        if (len_we && (len_wdata != '0)) begin
            len_d = len_wdata;
        end else begin
            len_d = len_q;
        end
        if (clear) begin
            state_d      = COUNT;
            count_d      = '0;
            block_done_d = 1'b0;
            overrun_d    = 1'b0;
        end else if (state_q == HOLD) begin
            if (cnt_up) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
            if (ack) begin
                state_d      = COUNT;
                count_d      = '0;
                block_done_d = 1'b0;
            end else begin
                state_d = HOLD;
            end
        end else if (complete_s) begin
            done_pulse_d = 1'b1;
            block_done_d = 1'b1;
            if (oneshot) begin
                count_d = len_q;
                state_d = HOLD;
            end else begin
                count_d = '0;
                if (block_done_q && !ack) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
        end else begin
            if (cnt_up) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q;
            end
            if (ack) begin
                block_done_d = 1'b0;
            end else begin
                block_done_d = block_done_q;
            end
        end
        active_d = (count_d != '0) || (state_d == HOLD);
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COUNT;
            count_q      <= '0;
            len_q        <= WIDTH'(DEFAULT_LEN);
            done_pulse_q <= 1'b0;
            block_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            len_q        <= len_d;
            done_pulse_q <= done_pulse_d;
            block_done_q <= block_done_d;
            overrun_q    <= overrun_d;
            active_q     <= active_d;
        end
    end

    assign count      = count_q;
    assign done_pulse = done_pulse_q;
    assign block_done = block_done_q;
    assign overrun    = overrun_q;
    assign active     = active_q;

endmodule

// File: rtl/sample_block_counter.sv
// Multi-channel sample block counter: replicates block_count_chan per channel,
// routes length writes to the addressed channel and merges busy.
module sample_block_counter
    import sample_count_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DEFAULT_LEN = DEF_LEN
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_CH-1:0]                             cnt_up,
    input  logic [NUM_CH-1:0]                             clear,
    input  logic [NUM_CH-1:0]                             ack,
    input  logic [NUM_CH-1:0]                             oneshot,
    input  logic                                          len_wr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] len_ch,
    input  logic [WIDTH-1:0]                              len_wdata,
    output logic [NUM_CH*WIDTH-1:0]                       count,
    output logic [NUM_CH-1:0]                             done_pulse,
    output logic [NUM_CH-1:0]                             block_done,
    output logic [NUM_CH-1:0]                             overrun,
    output logic                                          busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] len_we_s;
    logic [NUM_CH-1:0] active_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        // Out-of-range channel numbers match no instance, so the write is dropped
        assign len_we_s[i] = len_wr && (len_ch == CH_W'(i));

        block_count_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_LEN (DEFAULT_LEN)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .cnt_up     (cnt_up[i]),
            .clear      (clear[i]),
            .ack        (ack[i]),
            .oneshot    (oneshot[i]),
            .len_we     (len_we_s[i]),
            .len_wdata  (len_wdata),
            .count      (count[i*WIDTH +: WIDTH]),
            .done_pulse (done_pulse[i]),
            .block_done (block_done[i]),
            .overrun    (overrun[i]),
            .active     (active_s[i])
        );
    end

    assign busy = |active_s;

endmodule

// File: tb/tb_sample_block_counter.sv
// Self-checking bench for sample_block_counter: directed test-plan steps plus
// a randomized phase, all compared against a rule-level reference model.
module tb_sample_block_counter;

    localparam int W  = 10;
    localparam int NC = 3;
    localparam int DL = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] cnt_up = '0, clear = '0, ack = '0, oneshot = '0;
    logic          len_wr = 1'b0;
    logic [1:0]    len_ch = 2'd0;
    logic [W-1:0]  len_wdata = '0;
    logic [NC*W-1:0] count;
    logic [NC-1:0] done_pulse, block_done, overrun;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers per channel
    int m_cnt [NC];
    int m_len [NC];
    bit m_hold[NC];
    bit m_bd  [NC];
    bit m_ov  [NC];
    bit m_dp  [NC];

    sample_block_counter #(.WIDTH(W), .NUM_CH(NC), .DEFAULT_LEN(DL)) dut (
        .clk(clk), .rst(rst), .cnt_up(cnt_up), .clear(clear), .ack(ack),
        .oneshot(oneshot), .len_wr(len_wr), .len_ch(len_ch), .len_wdata(len_wdata),
        .count(count), .done_pulse(done_pulse), .block_done(block_done),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0; m_len[c] = DL; m_hold[c] = 1'b0;
            m_bd[c] = 1'b0; m_ov[c] = 1'b0; m_dp[c] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [NC-1:0] up, clr, ak, os,
                              input logic wr, input int ch, input int wd);
        for (int c = 0; c < NC; c++) begin
            m_dp[c] = 1'b0;
            if (clr[c]) begin
                m_cnt[c] = 0; m_bd[c] = 1'b0; m_ov[c] = 1'b0; m_hold[c] = 1'b0;
            end else if (m_hold[c]) begin
                if (up[c]) m_ov[c] = 1'b1;
                if (ak[c]) begin m_hold[c] = 1'b0; m_cnt[c] = 0; m_bd[c] = 1'b0; end
            end else if (up[c] && (m_cnt[c] + 1 >= m_len[c])) begin
                m_dp[c] = 1'b1;
                if (os[c]) begin
                    m_cnt[c] = m_len[c]; m_hold[c] = 1'b1;
                end else begin
                    if (m_bd[c] && !ak[c]) m_ov[c] = 1'b1;
                    m_cnt[c] = 0;
                end
                m_bd[c] = 1'b1;
            end else begin
                if (up[c]) m_cnt[c]++;
                if (ak[c]) m_bd[c] = 1'b0;
            end
        end
        if (wr && wd != 0 && ch < NC) m_len[ch] = wd;
    endtask

    task automatic compare_all();
        logic [NC-1:0] e_dp, e_bd, e_ov;
        logic e_busy;
        e_busy = 1'b0;
        for (int c = 0; c < NC; c++) begin
            check($sformatf("count%0d", c), 32'(count[c*W +: W]), 32'(m_cnt[c]));
            e_dp[c] = m_dp[c]; e_bd[c] = m_bd[c]; e_ov[c] = m_ov[c];
            if (m_cnt[c] != 0 || m_hold[c]) e_busy = 1'b1;
        end
        check("done_pulse", 32'(done_pulse), 32'(e_dp));
        check("block_done", 32'(block_done), 32'(e_bd));
        check("overrun",    32'(overrun),    32'(e_ov));
        check("busy",       32'(busy),       32'(e_busy));
    endtask

    task automatic cyc(input logic [NC-1:0] up, clr, ak, os,
                       input logic wr, input int ch, input int wd);
        @(negedge clk);
        cnt_up = up; clear = clr; ack = ak; oneshot = os;
        len_wr = wr; len_ch = 2'(ch); len_wdata = W'(wd);
        model_step(up, clr, ak, os, wr, ch, wd);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] cnt_of(input int c);
        return 32'(count[c*W +: W]);
    endfunction

    initial begin
        // Reset state
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Default length 1000, continuous on channel 0
        for (int k = 1; k < DL; k++) cyc(3'b001, '0, '0, '0, 1'b0, 0, 0);
        check("t1_pre_dp", 32'(done_pulse[0]), 32'd0);
        cyc(3'b001, '0, '0, '0, 1'b0, 0, 0);
        check("t1_dp", 32'(done_pulse[0]), 32'd1);
        check("t1_cnt", cnt_of(0), 32'd0);
        check("t1_bd", 32'(block_done[0]), 32'd1);
        cyc('0, '0, '0, '0, 1'b0, 0, 0);
        check("t1_dp_one_cycle", 32'(done_pulse[0]), 32'd0);
        cyc('0, '0, 3'b001, '0, 1'b0, 0, 0);

        // One-shot, len 4 on channel 1
        cyc('0, '0, '0, 3'b010, 1'b1, 1, 4);
        for (int k = 1; k <= 6; k++) begin
            cyc(3'b010, '0, '0, 3'b010, 1'b0, 0, 0);
            if (k == 4) check("t2_hold_cnt", cnt_of(1), 32'd4);
            if (k == 4) check("t2_ov_before", 32'(overrun[1]), 32'd0);
            if (k == 5) check("t2_ov", 32'(overrun[1]), 32'd1);
        end
        check("t2_cnt_held", cnt_of(1), 32'd4);
        cyc('0, '0, 3'b010, 3'b010, 1'b0, 0, 0);
        check("t2_ack_cnt", cnt_of(1), 32'd0);
        check("t2_ack_bd", 32'(block_done[1]), 32'd0);
        check("t2_ack_ov", 32'(overrun[1]), 32'd1);
        cyc('0, 3'b010, '0, '0, 1'b0, 0, 0);

        // Continuous overrun, len 3 on channel 2, without then with ack
        cyc('0, '0, '0, '0, 1'b1, 2, 3);
        for (int k = 1; k <= 6; k++) cyc(3'b100, '0, '0, '0, 1'b0, 0, 0);
        check("t3_ov", 32'(overrun[2]), 32'd1);
        cyc('0, 3'b100, '0, '0, 1'b0, 0, 0);
        for (int k = 1; k <= 5; k++) cyc(3'b100, '0, '0, '0, 1'b0, 0, 0);
        cyc(3'b100, '0, 3'b100, '0, 1'b0, 0, 0);
        check("t3_ack_bd", 32'(block_done[2]), 32'd1);
        check("t3_ack_ov", 32'(overrun[2]), 32'd0);

        // Shrink length mid-block
        cyc('0, 3'b100, '0, '0, 1'b1, 2, 10);
        for (int k = 1; k <= 7; k++) cyc(3'b100, '0, '0, '0, 1'b0, 0, 0);
        check("t4_cnt7", cnt_of(2), 32'd7);
        cyc('0, '0, '0, '0, 1'b1, 2, 5);
        check("t4_wr_no_cnt_change", cnt_of(2), 32'd7);
        cyc(3'b100, '0, '0, '0, 1'b0, 0, 0);
        check("t4_cnt", cnt_of(2), 32'd0);
        check("t4_dp", 32'(done_pulse[2]), 32'd1);

        // Clear together with a completing strobe
        for (int k = 1; k <= 4; k++) cyc(3'b100, '0, '0, '0, 1'b0, 0, 0);
        cyc(3'b100, 3'b100, '0, '0, 1'b0, 0, 0);
        check("t5_cnt", cnt_of(2), 32'd0);
        check("t5_dp", 32'(done_pulse[2]), 32'd0);
        check("t5_bd", 32'(block_done[2]), 32'd0);
        check("t5_ov", 32'(overrun[2]), 32'd0);

        // Ignored length writes: zero value and out-of-range channel
        cyc('0, '0, '0, '0, 1'b1, 2, 0);
        cyc('0, '0, '0, '0, 1'b1, 3, 2);
        for (int k = 1; k <= 5; k++) cyc(3'b100, '0, '0, '0, 1'b0, 0, 0);
        check("t6_len5_kept", 32'(done_pulse[2]), 32'd1);

        // len = 1 back-to-back strobes on channel 1
        cyc('0, 3'b010, '0, '0, 1'b1, 1, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc(3'b010, '0, '0, '0, 1'b0, 0, 0);
            check($sformatf("t7_dp%0d", k), 32'(done_pulse[1]), 32'd1);
            check($sformatf("t7_ov%0d", k), 32'(overrun[1]), (k >= 2) ? 32'd1 : 32'd0);
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic [NC-1:0] r_up, r_clr, r_ack, r_os;
            logic r_wr;
            r_up = NC'($urandom);
            r_os = NC'($urandom);
            for (int c = 0; c < NC; c++) begin
                r_clr[c] = ($urandom_range(0, 15) == 0);
                r_ack[c] = ($urandom_range(0, 3) == 0);
            end
            r_wr = ($urandom_range(0, 7) == 0);
            cyc(r_up, r_clr, r_ack, r_os, r_wr, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        end

        // Asynchronous reset mid-block, then default length must be back
        cyc('0, 3'b111, '0, '0, 1'b1, 0, 3);
        for (int k = 1; k <= 2; k++) cyc(3'b001, '0, '0, '0, 1'b0, 0, 0);
        @(negedge clk);
        cnt_up = '0; clear = '0; ack = '0; len_wr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t8_async_cnt", cnt_of(0), 32'd0);
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k < DL; k++) cyc(3'b001, '0, '0, '0, 1'b0, 0, 0);
        check("t8_no_early_dp", 32'(done_pulse[0]), 32'd0);
        cyc(3'b001, '0, '0, '0, 1'b0, 0, 0);
        check("t8_len_default", 32'(done_pulse[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_block_counter.md
# sample_block_counter

Parametrised, multi-channel successor to the single fixed-length sample counter in the AHB-Lite FIR accelerator datapath. Each channel counts sample-valid strobes and flags completion of a block whose length is programmable at run time. Each channel runs in continuous (auto-wrap) or one-shot (hold until acknowledged) mode and reports overrun when a block completes before the previous one was acknowledged. It sits between the AHB-Lite slave register file, which supplies lengths, mode and acks, and the FIR sample path, which supplies strobes.

## Interface
Parameters:
- WIDTH, 10, counter and length width in bits
- NUM_CH, 2, number of independent channels (1..8)
- DEFAULT_LEN, 1000, block length loaded on reset (1..2**WIDTH-1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cnt_up  in  NUM_CH  per-channel sample strobe
- clear  in  NUM_CH  per-channel synchronous clear
- ack  in  NUM_CH  per-channel completion acknowledge
- oneshot  in  NUM_CH  per-channel mode: 1 = one-shot, 0 = continuous
- len_wr  in  1  length write strobe
- len_ch  in  $clog2(NUM_CH) (min 1)  target channel of the length write
- len_wdata  in  WIDTH  new block length
- count  out  NUM_CH*WIDTH  per-channel count, channel i at [i*WIDTH +: WIDTH]
- done_pulse  out  NUM_CH  one-cycle completion pulse
- block_done  out  NUM_CH  sticky completion flag
- overrun  out  NUM_CH  sticky overrun flag
- busy  out  1  OR over channels of (count != 0, or state == HOLD)

## Operation
- Per-channel state: COUNT, HOLD. Reset state is COUNT, len = DEFAULT_LEN, and every output is 0.
- Length write: when len_wr is high, len[len_ch] <= len_wdata. A write of 0 is ignored, as is a write to a len_ch >= NUM_CH. Count and state are untouched.
- Completion event: cnt_up high in COUNT with count >= len-1. Use >= so that shrinking len mid-block completes on the next strobe.
- COUNT, non-completing cnt_up: count increments by 1.
- COUNT, completion:
  - done_pulse <= 1 and block_done <= 1.
  - Continuous mode: count <= 0, stay in COUNT.
  - One-shot mode: count <= len, go to HOLD.
  - oneshot is sampled on the completing cycle.
- HOLD:
  - cnt_up sets overrun; count holds.
  - ack or clear returns the channel to COUNT with count <= 0.
- Overrun, continuous mode: a completion while block_done is already 1 and ack is low sets overrun.
- ack clears block_done. If ack and a completion occur in the same cycle, the completion wins: block_done stays 1 and overrun is not set.
- clear: highest priority over cnt_up and ack. Sets count <= 0, block_done, overrun and done_pulse to 0, state COUNT. It does not touch len.
- Reset mid-operation: all channels return to reset values immediately (asynchronous), and len reverts to DEFAULT_LEN.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- count updates on the clock edge that samples cnt_up.
- done_pulse and block_done assert at the same edge on which count wraps or saturates. done_pulse is high for exactly one cycle.
- A length write is visible to the completion compare on the cycle after len_wr.
- Back-to-back strobes are accepted every cycle. With len = 1, each strobe completes: done_pulse stays high continuously in continuous mode, and overrun follows from the second strobe if no ack is given.
- busy reflects post-edge register state.

## Structure
- Package sample_count_pkg holds:
  - typedef enum logic {COUNT, HOLD} chan_state_t
  - the default parameter constants
- Sub-module block_count_chan implements one channel: state, count, len and the three flags. It has a per-channel len write enable.
- The top generates NUM_CH instances, decodes len_ch into the per-channel len write enables, packs count, and ORs busy.

## Test plan
- Reset, then 1000 strobes on channel 0 in continuous mode -> done_pulse high for one cycle after strobe 1000; count = 0; block_done = 1.
- Write len = 4 to channel 1 in one-shot mode, then 6 strobes -> count = 4 and state HOLD after strobe 4; overrun = 1 after strobe 5; ack -> count = 0, block_done = 0, overrun still 1.
- Continuous, len = 3, 6 strobes with no ack -> overrun = 1 at strobe 6. Repeat with ack asserted in the same cycle as strobe 6 -> block_done = 1, overrun = 0.
- Count to 7 with len = 10, then write len = 5, then one strobe -> completion, count = 0.
- clear asserted together with a completing strobe -> count = 0, done_pulse = 0, flags = 0. Asserting rst mid-block -> count = 0 immediately; len reverts to 1000.
- Write len = 0, and write with len_ch = NUM_CH -> no length change on any channel.
